iter_shifter: RTL and testbench
===============================

Name: iter_shifter

Overview:
- Multi-cycle, one-bit-per-clock shifter for the ALU datapath. It provides the opposite-direction operations to the single-cycle combinational shifter: logical shift right and rotate left.
- Uses a start/ready/done handshake so the issue stage can stall on it.
- Result is held stable until the next accepted operation.

Parameters:
WIDTH, 16, data width in bits
CNT_W, $clog2(WIDTH) (4), width of shift amount and internal counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
Start  input  1  request; sampled only when Ready=1
Mode  input  2  operation: 00 SRL, 01 ROL, 10/11 reserved (pass-through)
Shift_In  input  WIDTH  operand, captured when Start is accepted
Shift_Val  input  CNT_W  shift amount 0..WIDTH-1, captured when Start is accepted
Ready  output  1  high in IDLE and DONE; Start accepted when Start&Ready
Busy  output  1  high in SHIFT
Done  output  1  one-cycle pulse when result is valid
Shift_Out  output  WIDTH  result register

Behaviour:
- Reset (synchronous, active-high, applies in any state, including mid-operation):
  - state <= IDLE.
  - Shift_Out, Done, Busy and the counter all <= 0.
  - Ready = 1 in the cycle after reset.
  - An operation in flight is discarded.
- State machine (states IDLE, SHIFT, DONE):
  - IDLE: Start&Ready captures Mode, Shift_In into the data register and Shift_Val into the counter. Go to SHIFT if Shift_Val != 0, otherwise go to DONE.
  - SHIFT: each cycle shifts the data register one bit per Mode and decrements the counter. When the counter reaches 1 (the last shift), go to DONE.
  - DONE: Done=1 for exactly this cycle, and Shift_Out shows the final value.
    - Start accepted here: behaves as in IDLE (back-to-back issue allowed).
    - Otherwise: go to IDLE.
- Latency: Done is high exactly Shift_Val+1 cycles after the edge at which Start was accepted (Shift_Val=0 gives 1 cycle).
- Shift_Out tracks the data register. It holds its value in IDLE, and it changes only after a new Start is accepted.
- Start while Busy is ignored; no queuing.
- SRL: zero-fill from the MSB; bit 0 is discarded.
- ROL: the MSB wraps into bit 0.
- Reserved modes: the counter still runs and the data is unchanged. Result = Shift_In, with the same latency.
- Width rules:
  - The counter is CNT_W bits wide, and Shift_Val = WIDTH-1 is the maximum (no overflow).
  - After WIDTH-1 SRL steps only the original MSB can survive, in bit 0.

Optional Feature:
- Macro SHIFTER_FLAGS_EN.
- When defined:
  - Adds outputs Zero (1 bit) and Carry (1 bit), both registered.
  - Updated in the same cycle as Shift_Out reaches its final value; held until the next accept; cleared on reset.
  - Zero = (Shift_Out == 0).
  - Carry = the last bit shifted out under SRL, or the last bit wrapped under ROL. It is 0 when Shift_Val=0 or Mode is reserved.
- When undefined: ports are absent and there is no flag logic.

Decomposition:
- Package shifter_pkg holds:
  - typedef shift_mode_t (SRL=2'b00, ROL=2'b01, RSV2, RSV3);
  - typedef shift_state_t (IDLE, SHIFT, DONE);
  - localparam DATA_W=16.
- One combinational sub-module, shift_step, computes a single-bit SRL/ROL plus the bit moved out. iter_shifter instantiates it once.

Test Plan:
- Reset held 2 cycles, then released -> Ready=1, Busy=0, Done=0, Shift_Out=0x0000.
- Mode=00, Shift_In=0x8001, Shift_Val=1 -> Done 2 cycles after accept, Shift_Out=0x4000. Mode=00, 0xFFFF, Val=15 -> Done after 16 cycles, Shift_Out=0x0001.
- Mode=01, Shift_In=0x1824, Shift_Val=4 -> Done 5 cycles after accept, Shift_Out=0x8241. Sweep Val 0..15 against a model rotate.
- Shift_Val=0, Mode=01, Shift_In=0xBEEF -> Done 1 cycle after accept, Shift_Out=0xBEEF. Mode=11, 0x1234, Val=3 -> Shift_Out=0x1234 after 4 cycles.
- Start re-pulsed with new operands while Busy -> ignored, original result unchanged. Start in the Done cycle -> new op accepted, no IDLE bubble.
- rst asserted in the middle of a Val=10 shift -> next cycle IDLE, Shift_Out=0, no Done pulse. With SHIFTER_FLAGS_EN: SRL 0x0001 by 1 -> Shift_Out=0, Zero=1, Carry=1.

Source files
------------

// File: rtl/iter_shifter_pkg.sv
// Shared types and sizes for the iterative shifter (package shifter_pkg).
package shifter_pkg;
  localparam int DATA_W = 16;
  localparam int CNT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    SRL  = 2'b00,
    ROL  = 2'b01,
    RSV2 = 2'b10,
    RSV3 = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shift_state_t;
endpackage

// File: rtl/iter_shifter_if.sv
// Issue-side handshake bundle for iter_shifter. SHIFTER_FLAGS_EN adds Zero/Carry.
interface iter_shifter_if
  import shifter_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = $clog2(WIDTH)
) ();
  logic             Start;
  logic [1:0]       Mode;
  logic [WIDTH-1:0] Shift_In;
  logic [CNT_W-1:0] Shift_Val;
  logic             Ready;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Shift_Out;
`ifdef SHIFTER_FLAGS_EN
  logic             Zero;
  logic             Carry;

  modport master (output Start, Mode, Shift_In, Shift_Val,
                  input  Ready, Busy, Done, Shift_Out, Zero, Carry);
  modport slave  (input  Start, Mode, Shift_In, Shift_Val,
                  output Ready, Busy, Done, Shift_Out, Zero, Carry);
`else
  modport master (output Start, Mode, Shift_In, Shift_Val,
                  input  Ready, Busy, Done, Shift_Out);
  modport slave  (input  Start, Mode, Shift_In, Shift_Val,
                  output Ready, Busy, Done, Shift_Out);
`endif
endinterface

// File: rtl/iter_shifter_step.sv
// One-bit SRL/ROL step; reserved modes pass data through.
// The moved-out bit is only brought out when SHIFTER_FLAGS_EN is defined.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] data_i,
  input  shift_mode_t      mode_i,
`ifdef SHIFTER_FLAGS_EN
  output logic             bit_o,
`endif
  output logic [WIDTH-1:0] data_o
);
  logic moved;

  always_comb begin
    data_o = data_i;
    moved  = 1'b0;
    case (mode_i)
      SRL: begin
        data_o = {1'b0, data_i[WIDTH-1:1]};
        moved  = data_i[0];
      end
      ROL: begin
        data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
        moved  = data_i[WIDTH-1];
      end
      default: begin
        data_o = data_i;
        moved  = 1'b0;
      end
    endcase
  end

`ifdef SHIFTER_FLAGS_EN
  assign bit_o = moved;
`else
  logic unused_moved;
  assign unused_moved = moved;
`endif
endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle one-bit-per-clock SRL/ROL shifter with start/ready/done handshake.
// SHIFTER_FLAGS_EN adds registered Zero/Carry result flags.
module iter_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  iter_shifter_if.slave bus
);
  shift_state_t     state_q;
  shift_mode_t      mode_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] step_d;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q, busy_q, done_q;
`ifdef SHIFTER_FLAGS_EN
  logic             step_bit;
  logic             zero_q, carry_q;
`endif

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data_i (data_q),
    .mode_i (mode_q),
`ifdef SHIFTER_FLAGS_EN
    .bit_o  (step_bit),
`endif
    .data_o (step_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= SRL;
      data_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHIFTER_FLAGS_EN
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.Start) begin
            mode_q <= shift_mode_t'(bus.Mode);
            data_q <= bus.Shift_In;
            cnt_q  <= bus.Shift_Val;
            if (bus.Shift_Val == '0) begin
              // Zero-length op finishes immediately with the operand as result
              state_q <= DONE;
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
`ifdef SHIFTER_FLAGS_EN
              zero_q  <= (bus.Shift_In == '0);
              carry_q <= 1'b0;
`endif
            end else begin
              state_q <= SHIFT;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        SHIFT: begin
          data_q <= step_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef SHIFTER_FLAGS_EN
            zero_q  <= (step_d == '0);
            carry_q <= step_bit;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Ready     = ready_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Shift_Out = data_q;
`ifdef SHIFTER_FLAGS_EN
  assign bus.Zero      = zero_q;
  assign bus.Carry     = carry_q;
`endif
endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter: expected result/latency queued at issue, checked at Done.
module tb_iter_shifter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [15:0] d;
    int          lat;
    logic        z;
    logic        c;
  } exp_t;

  exp_t sb[$];

  iter_shifter_if #(.WIDTH(16), .CNT_W(4)) bus ();
  iter_shifter #(.WIDTH(16), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] m, input logic [15:0] x, input logic [3:0] v);
    exp_t e;
    e.lat = int'(v) + 1;
    e.c   = 1'b0;
    e.d   = x;
    case (m)
      2'b00: begin
        e.d = x >> v;
        if (v != 0) e.c = x[int'(v) - 1];
      end
      2'b01: begin
        if (v != 0) begin
          e.d = (x << v) | (x >> (16 - int'(v)));
          e.c = e.d[0];
        end
      end
      default: e.d = x;
    endcase
    e.z = (e.d == 16'h0000);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge one cycle after the accept edge.
  task automatic issue(input logic [1:0] m, input logic [15:0] x, input logic [3:0] v);
    int n;
    n = 0;
    while (bus.Ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL issue_ready_timeout: Ready=%b required 1", bus.Ready);
    end
    bus.Start = 1'b1; bus.Mode = m; bus.Shift_In = x; bus.Shift_Val = v;
    sb.push_back(model(m, x, v));
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  task automatic wait_done(input int cyc0);
    exp_t e;
    int   cyc;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: size=0 required >0");
      return;
    end
    e = sb.pop_front();
    cyc = cyc0;
    while (bus.Done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (bus.Done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: Done=%b required 1", bus.Done);
    end else begin
      checks++;
      if (cyc !== e.lat) begin
        errors++;
        $display("FAIL latency: got %0d cycles required %0d", cyc, e.lat);
      end
      checks++;
      if (bus.Shift_Out !== e.d) begin
        errors++;
        $display("FAIL result: Shift_Out=%h required %h", bus.Shift_Out, e.d);
      end
      checks++;
      if (bus.Ready !== 1'b1 || bus.Busy !== 1'b0) begin
        errors++;
        $display("FAIL done_handshake: Ready=%b Busy=%b required 1 0", bus.Ready, bus.Busy);
      end
`ifdef SHIFTER_FLAGS_EN
      checks++;
      if (bus.Zero !== e.z || bus.Carry !== e.c) begin
        errors++;
        $display("FAIL flags: Zero=%b Carry=%b required %b %b", bus.Zero, bus.Carry, e.z, e.c);
      end
`endif
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.Ready !== 1'b1 || bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Shift_Out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: Ready=%b Busy=%b Done=%b Out=%h required 1 0 0 0000",
               bus.Ready, bus.Busy, bus.Done, bus.Shift_Out);
    end
  endtask

  task automatic test_srl();
    issue(2'b00, 16'h8001, 4'd1);
    wait_done(1);
    checks++;
    if (bus.Shift_Out !== 16'h4000) begin
      errors++;
      $display("FAIL srl_8001_by1: Out=%h required 4000", bus.Shift_Out);
    end
    @(negedge clk);
    checks++;
    if (bus.Done !== 1'b0 || bus.Ready !== 1'b1 || bus.Shift_Out !== 16'h4000) begin
      errors++;
      $display("FAIL done_pulse_width: Done=%b Ready=%b Out=%h required 0 1 4000",
               bus.Done, bus.Ready, bus.Shift_Out);
    end
    issue(2'b00, 16'hFFFF, 4'd15);
    wait_done(1);
    checks++;
    if (bus.Shift_Out !== 16'h0001) begin
      errors++;
      $display("FAIL srl_ffff_by15: Out=%h required 0001", bus.Shift_Out);
    end
    @(negedge clk);
    issue(2'b00, 16'h7FFF, 4'd15);
    wait_done(1);
    @(negedge clk);
  endtask

  task automatic test_rol();
    logic [15:0] x;
    issue(2'b01, 16'h1824, 4'd4);
    wait_done(1);
    checks++;
    if (bus.Shift_Out !== 16'h8241) begin
      errors++;
      $display("FAIL rol_1824_by4: Out=%h required 8241", bus.Shift_Out);
    end
    @(negedge clk);
    for (int v = 0; v < 16; v++) begin
      x = 16'($urandom);
      issue(2'b01, x, 4'(v));
      wait_done(1);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_and_reserved();
    issue(2'b01, 16'hBEEF, 4'd0);
    wait_done(1);
    checks++;
    if (bus.Shift_Out !== 16'hBEEF) begin
      errors++;
      $display("FAIL zero_shift: Out=%h required beef", bus.Shift_Out);
    end
    @(negedge clk);
    issue(2'b11, 16'h1234, 4'd3);
    wait_done(1);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.Shift_Out !== 16'h1234 || bus.Ready !== 1'b1 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL reserved_hold: Out=%h Ready=%b Busy=%b required 1234 1 0",
               bus.Shift_Out, bus.Ready, bus.Busy);
    end
    issue(2'b10, 16'h00F0, 4'd7);
    wait_done(1);
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    issue(2'b00, 16'hF0F0, 4'd8);
    checks++;
    if (bus.Busy !== 1'b1 || bus.Ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_flag: Busy=%b Ready=%b required 1 0", bus.Busy, bus.Ready);
    end
    bus.Start = 1'b1; bus.Mode = 2'b01; bus.Shift_In = 16'h1111; bus.Shift_Val = 4'd2;
    repeat (2) @(negedge clk);
    bus.Start = 1'b0;
    wait_done(3);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    issue(2'b00, 16'hA5A5, 4'd3);
    wait_done(1);
    issue(2'b01, 16'h8000, 4'd1);
    wait_done(1);
    issue(2'b00, 16'h0F00, 4'd0);
    wait_done(1);
    issue(2'b01, 16'hC003, 4'd2);
    wait_done(1);
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int saw_done;
    exp_t dropped;
    issue(2'b00, 16'hABCD, 4'd10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.Ready !== 1'b1 || bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Shift_Out !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset_state: Ready=%b Busy=%b Done=%b Out=%h required 1 0 0 0000",
               bus.Ready, bus.Busy, bus.Done, bus.Shift_Out);
    end
    rst = 1'b0;
    if (sb.size() > 0) dropped = sb.pop_front();
    saw_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.Done === 1'b1) saw_done++;
    end
    checks++;
    if (saw_done != 0 || bus.Shift_Out !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset_discard: done_pulses=%0d Out=%h required 0 0000", saw_done, bus.Shift_Out);
    end
  endtask

`ifdef SHIFTER_FLAGS_EN
  task automatic test_flags();
    issue(2'b00, 16'h0001, 4'd1);
    wait_done(1);
    checks++;
    if (bus.Shift_Out !== 16'h0000 || bus.Zero !== 1'b1 || bus.Carry !== 1'b1) begin
      errors++;
      $display("FAIL flags_srl_0001: Out=%h Zero=%b Carry=%b required 0000 1 1",
               bus.Shift_Out, bus.Zero, bus.Carry);
    end
    @(negedge clk);
    issue(2'b01, 16'h4000, 4'd2);
    wait_done(1);
    issue(2'b11, 16'h0000, 4'd2);
    wait_done(1);
    @(negedge clk);
  endtask
`endif

  initial begin
    bus.Start = 1'b0; bus.Mode = 2'b00; bus.Shift_In = '0; bus.Shift_Val = '0;
    test_reset();
    test_srl();
    test_rol();
    test_zero_and_reserved();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
`ifdef SHIFTER_FLAGS_EN
    test_flags();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
